// File: rtl/alu_exec_stage.sv
// Execute stage: ALU ops registered into a single EX/MEM output slot with valid/ready.
// Shifts are serial (1 bit/cycle, 1+shamt latency) unless FAST_SHIFT; flush kills in-flight work.
module alu_exec_stage #(
  parameter int XLEN       = 32,
  parameter bit FAST_SHIFT = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_decode,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [4:0]      rd_out,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0010;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [3:0]      sh_op_q, sh_op_d;
  logic [4:0]      rd_pend_q, rd_pend_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic [4:0]      rd_q, rd_d;

  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic            accept;
  logic            go_serial;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] step_res;
  logic            slot_wr;
  logic [XLEN-1:0] slot_res;
  logic [4:0]      slot_rd;

  assign shamt    = op_b[SHW-1:0];
  assign is_shift = (alu_decode == OP_SLL) || (alu_decode == OP_SRL) || (alu_decode == OP_SRA);
  assign in_ready = (state_q == IDLE) && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign go_serial = accept && is_shift && !FAST_SHIFT && (shamt != '0);

  always_comb begin
    alu_res = '0;
    case (alu_decode)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: alu_res = '0;
    endcase
  end

  // One bit of the serial shifter; sh_op_q only ever holds a shift code.
  always_comb begin
    step_res = work_q;
    case (sh_op_q)
      OP_SLL:  step_res = {work_q[XLEN-2:0], 1'b0};
      OP_SRL:  step_res = {1'b0, work_q[XLEN-1:1]};
      OP_SRA:  step_res = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: step_res = work_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    sh_op_d     = sh_op_q;
    rd_pend_d   = rd_pend_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    rd_d        = rd_q;
    slot_wr     = 1'b0;
    slot_res    = alu_res;
    slot_rd     = rd_in;

    if (state_q == SHIFT) begin
      work_d = step_res;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == SHW'(1)) begin
        slot_wr  = 1'b1;
        slot_res = step_res;
        slot_rd  = rd_pend_q;
        state_d  = IDLE;
      end
    end else if (go_serial) begin
      work_d    = op_a;
      cnt_d     = shamt;
      sh_op_d   = alu_decode;
      rd_pend_d = rd_in;
      state_d   = SHIFT;
    end else if (accept) begin
      slot_wr = 1'b1;
    end

    // A write in the same edge as a drain keeps out_valid high.
    if (slot_wr) begin
      out_valid_d = 1'b1;
      result_d    = slot_res;
      zero_d      = (slot_res == '0);
      rd_d        = slot_rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      sh_op_q     <= OP_SLL;
      rd_pend_q   <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      sh_op_q     <= sh_op_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      rd_q        <= rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign rd_out    = rd_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed ops push expected results, a negedge monitor pops on handshake.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_decode;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic [4:0]  rd_out;
  logic        busy;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  alu_exec_stage #(.XLEN(32), .FAST_SHIFT(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_decode(alu_decode), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .rd_out(rd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Handshake completes on the following posedge; inputs are stable at the negedge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %h rd %0d, expected no output", result, rd_out);
      end else begin
        e = sb.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_zero", {31'b0, zero}, {31'b0, (e.res == 32'h0)});
        chk("sb_rd", {27'b0, rd_out}, {27'b0, e.rd});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input bit push);
    int n;
    in_valid   = 1'b1;
    alu_decode = op;
    op_a       = a;
    op_b       = b;
    rd_in      = rd;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready stayed 0, required 1 within 50 cycles");
    end else if (push) begin
      sb.push_back('{res: exp, rd: rd});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b1; in_valid = 1'b0; alu_decode = 4'h0; op_a = '0; op_b = '0;
    rd_in = '0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'h0);
    chk("rst_rd", {27'b0, rd_out}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", {31'b0, in_ready}, 32'h1);

    // Back-to-back arithmetic with wrap-around
    issue(4'b0000, 32'h7FFF_FFFF, 32'h1, 5'd1, 32'h8000_0000, 1'b1);
    chk("b2b_in_ready", {31'b0, in_ready}, 32'h1);
    chk("b2b_out_valid", {31'b0, out_valid}, 32'h1);
    issue(4'b1000, 32'd5, 32'd7, 5'd2, 32'hFFFF_FFFE, 1'b1);
    chk("sub_out_valid", {31'b0, out_valid}, 32'h1);
    issue(4'b0110, 32'hFFFF_FFFF, 32'h1, 5'd3, 32'h1, 1'b1);
    issue(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd4, 32'h0, 1'b1);
    issue(4'b0101, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 5'd5, 32'h0, 1'b1);

    // Serial SRA by 4: busy for 4 cycles, result after the 4th shift edge
    issue(4'b1010, 32'h8000_0000, 32'd4, 5'd6, 32'hF800_0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("sra_busy", {31'b0, busy}, 32'h1);
      chk("sra_in_ready", {31'b0, in_ready}, 32'h0);
      chk("sra_no_out", {31'b0, out_valid}, 32'h0);
      tick();
    end
    chk("sra_done_busy", {31'b0, busy}, 32'h0);
    chk("sra_done_valid", {31'b0, out_valid}, 32'h1);
    chk("sra_done_result", result, 32'hF800_0000);

    // Only the low 5 bits of op_b count: 0x24 shifts by 4
    issue(4'b0010, 32'hF000_0000, 32'h24, 5'd7, 32'h0F00_0000, 1'b1);
    issue(4'b0001, 32'h1234_5678, 32'h0, 5'd8, 32'h1234_5678, 1'b1);
    chk("sll0_valid", {31'b0, out_valid}, 32'h1);
    chk("sll0_busy", {31'b0, busy}, 32'h0);
    chk("sll0_result", result, 32'h1234_5678);

    // Back-pressure: slot holds, then same-edge drain and refill
    tick();
    out_ready = 1'b0;
    issue(4'b0000, 32'd3, 32'd4, 5'd10, 32'd7, 1'b1);
    in_valid = 1'b1; alu_decode = 4'b0100; op_a = 32'hF0F0_0000; op_b = 32'h0000_F0F0; rd_in = 5'd11;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
      chk("bp_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_result_hold", result, 32'd7);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'h1);
    sb.push_back('{res: 32'hF0F0_F0F0, rd: 5'd11});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("refill_valid", {31'b0, out_valid}, 32'h1);
    chk("refill_result", result, 32'hF0F0_F0F0);
    chk("refill_rd", {27'b0, rd_out}, 32'd11);

    // Flush in the middle of a 20-bit SRL
    issue(4'b0010, 32'hFFFF_0000, 32'd20, 5'd12, 32'h0, 1'b0);
    repeat (4) tick();
    chk("fl_busy", {31'b0, busy}, 32'h1);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", {31'b0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fl_idle", {31'b0, busy}, 32'h0);
    chk("fl_no_valid", {31'b0, out_valid}, 32'h0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | out_valid;
    end
    chk("fl_never_out", {31'b0, seen}, 32'h0);
    issue(4'b0000, 32'd10, 32'd20, 5'd9, 32'd30, 1'b1);
    chk("post_fl_valid", {31'b0, out_valid}, 32'h1);
    chk("post_fl_rd", {27'b0, rd_out}, 32'd9);
    tick();

    // Reset with a full, stalled slot
    out_ready = 1'b0;
    issue(4'b0000, 32'd1, 32'd1, 5'd13, 32'd2, 1'b0);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    reset = 1'b1;
    tick();
    chk("rst1_valid", {31'b0, out_valid}, 32'h0);
    chk("rst1_result", result, 32'h0);
    chk("rst1_zero", {31'b0, zero}, 32'h0);
    chk("rst1_rd", {27'b0, rd_out}, 32'h0);
    reset = 1'b0;
    out_ready = 1'b1;

    // Reset in the middle of a serial shift
    issue(4'b0001, 32'h1, 32'd10, 5'd14, 32'h0, 1'b0);
    tick(); tick();
    chk("rst2_pre_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_busy", {31'b0, busy}, 32'h0);
    chk("rst2_valid", {31'b0, out_valid}, 32'h0);
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | out_valid;
    end
    chk("rst2_never_out", {31'b0, seen}, 32'h0);

    // Unlisted code produces zero in one cycle
    issue(4'b1111, 32'd5, 32'd6, 5'd15, 32'h0, 1'b1);
    chk("bad_op_valid", {31'b0, out_valid}, 32'h1);
    chk("bad_op_result", result, 32'h0);
    chk("bad_op_zero", {31'b0, zero}, 32'h1);

    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage datapath directly downstream of the ALU control decoder: consumes its 4-bit alu_decode code plus the two operands and performs the operation.
- Registers the result into the EX/MEM output slot under a valid/ready handshake.
- Shifts are serial, one bit per cycle, unless FAST_SHIFT is set. This makes the stage variable-latency with back-pressure and a flush.

Parameters:
- XLEN, 32, operand/result width; shift amount is op_b[$clog2(XLEN)-1:0].
- FAST_SHIFT, 0, 1 = all shifts complete in one cycle (barrel); 0 = serial shifter, 1 bit/cycle.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  operation presented
- in_ready  output  1  stage can accept this cycle
- alu_decode  input  4  op code: ADD 0000, SUB 1000, SLL 0001, SRL 0010, SRA 1010, AND 0011, OR 0100, XOR 0101, SLT 0110, SLTU 0111
- op_a  input  XLEN  operand A / shift source
- op_b  input  XLEN  operand B / shift amount
- rd_in  input  5  destination register tag
- flush  input  1  synchronous kill of in-flight and output-slot contents
- out_valid  output  1  result slot full
- out_ready  input  1  downstream accepts slot
- result  output  XLEN  registered result
- zero  output  1  registered (result == 0)
- rd_out  output  5  registered tag
- busy  output  1  serial shift in progress (state == SHIFT)

Behaviour:
- Reset (sync, active-high): state IDLE, out_valid 0, result 0, zero 0, rd_out 0, busy 0, shift counter 0. Reset mid-shift aborts the shift and produces no output.
- States: IDLE, SHIFT.
- in_ready = (state == IDLE) && !flush && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Output slot update when out_valid && !out_ready: result, zero and rd_out hold. When out_ready && no new write: out_valid clears.
- Non-shift op, or shift with shamt 0, or FAST_SHIFT=1, accepted at edge E0: slot written at E0, out_valid=1 after E0 (1-cycle latency).
- Shift with shamt k ≥ 1 and FAST_SHIFT=0, accepted at E0:
  - E0: work=op_a, cnt=k, rd latched, state→SHIFT.
  - Each SHIFT edge: work shifted 1 bit (SLL zero-fill left, SRL zero-fill right, SRA sign-fill right), cnt−1.
  - Edge where cnt==1: shifted value written to slot, out_valid=1, state→IDLE.
  - Latency 1+k cycles. The slot is guaranteed empty at completion because no acceptance occurs while in SHIFT.
- Arithmetic:
  - ADD/SUB wrap mod 2^XLEN.
  - SLT signed, SLTU unsigned; both write 1 or 0.
  - Shift amount uses only low $clog2(XLEN) bits of op_b.
- Unlisted codes (1001, 1011–1111): result 0, zero 1, still produce a normal 1-cycle output.
- flush (priority over accept, below reset):
  - Clears out_valid.
  - SHIFT→IDLE with work discarded.
  - in_ready forced 0 that cycle, so no acceptance.
  - result/rd_out need not clear.
- Simultaneous out_ready and accept: old slot drains and new value is written the same edge; out_valid stays 1.

Test Plan:
- ADD 0x7FFFFFFF+1, then SUB 5−7, out_ready=1: results 0x80000000 then 0xFFFFFFFE on consecutive cycles; in_ready stays 1.
- SLT vs SLTU with op_a=0xFFFFFFFF, op_b=1: SLT→1, SLTU→0. XOR 0xA5A5A5A5^0xA5A5A5A5 → result 0, zero=1.
- SRA op_a=0x80000000, op_b=4, FAST_SHIFT=0: busy=1 for 4 cycles, in_ready=0 throughout, result 0xF8000000 at 5 cycles after acceptance. SLL op_b=0 completes in 1 cycle, result=op_a.
- Back-pressure: out_ready=0 with slot full → in_ready=0, slot holds for 3 cycles. Raise out_ready while in_valid=1 → same-edge drain+refill, out_valid continuous.
- flush during SHIFT (SRL op_b=20, flush at cycle 5): state IDLE next cycle, no out_valid ever for that op, and the following ADD completes normally with rd_out correct.
- reset asserted with out_valid=1 and mid-shift: all outputs return to reset values next edge. Unlisted code 1111 produces result 0 in 1 cycle.
